// File: rtl/hist_sc_tbl_gen.sv
// rtl/hist_sc_tbl_gen.sv - CDF-to-scale-table generator, optional round-to-nearest via HIST_SC_ROUND_EN
module hist_sc_tbl_gen #(
    parameter int CDF_DEPTH = 64,
    parameter int SC_DEPTH  = 16
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         enable,
    input  logic [31:0]  total_pix,
    output logic [15:0]  cdf_mem_rd_addr,
    input  logic [127:0] cdf_mem_rd_data,
    output logic [15:0]  sc_mem_wt_addr,
    output logic [127:0] sc_mem_wt_data,
    output logic         sc_mem_wt_en,
    output logic         div_sc_mem_wt_done,
    output logic         busy
);

    localparam int CW = $clog2(CDF_DEPTH);
    localparam int MW = $clog2(SC_DEPTH);

    typedef enum logic [2:0] {
        S_IDLE,
        S_MIN_RD,
        S_MIN_CHK,
        S_MAP_RD,
        S_MAP_LD,
        S_DIV,
        S_WR,
        S_DONE
    } state_t;

    state_t         r_state;
    state_t         w_next;

    logic [31:0]    r_total;
    logic [31:0]    r_cdf_min;
    logic [31:0]    r_rem;
    logic [CW-1:0]  r_w;
    logic [CW-1:0]  r_k;
    logic [MW-1:0]  r_m;
    logic [1:0]     r_j;
    logic [3:0]     r_div_cnt;
    logic [127:0]   r_word;
    logic [127:0]   r_pack;
    logic [7:0]     r_numlo;
    logic [6:0]     r_q;
    logic           r_sat;
    logic           r_zero;
    logic [15:0]    r_rd_addr;

    logic           w_min_found;
    logic [31:0]    w_min_val;
    logic [31:0]    w_entry;
    logic [31:0]    w_diff;
    logic           w_below;
    logic [31:0]    w_den;
    logic [40:0]    w_prod;
    logic [40:0]    w_num;
    logic [32:0]    w_num_hi;
    logic           w_ovf;
    logic [32:0]    w_rem_sh;
    logic           w_ge;
    logic [31:0]    w_sub;
    logic [31:0]    w_rem_nx;
    logic [7:0]     w_q_fin;
    logic [7:0]     w_byte;
    logic           w_last_div;
    logic           w_last_entry;
    logic           w_pack_full;
    logic           w_last_k;
    logic           w_last_w;
    logic [CW-1:0]  w_w_inc;
    logic [CW-1:0]  w_k_inc;

    // Lowest-index nonzero entry of the word currently on the read bus
    always_comb begin
        w_min_found = 1'b0;
        w_min_val   = 32'd0;
        for (int i = 3; i >= 0; i--) begin
            if (cdf_mem_rd_data[32*i +: 32] != 32'd0) begin
                w_min_found = 1'b1;
                w_min_val   = cdf_mem_rd_data[32*i +: 32];
            end
        end
    end

    assign w_entry  = r_word[{r_j, 5'b00000} +: 32];
    assign w_below  = (w_entry < r_cdf_min);
    assign w_diff   = w_entry - r_cdf_min;
    assign w_den    = r_total - r_cdf_min;
    assign w_prod   = ({9'd0, w_diff} << 8) - {9'd0, w_diff};

`ifdef HIST_SC_ROUND_EN
    assign w_num    = w_prod + {10'd0, w_den[31:1]};
`else
    assign w_num    = w_prod;
`endif

    // Upper bits >= den means the quotient needs more than 8 bits: saturate.
    // Otherwise the upper bits are the starting remainder for the 8 steps.
    assign w_num_hi = w_num[40:8];
    assign w_ovf    = (w_num_hi >= {1'b0, w_den});

    // One restoring step; the true difference is below den, so 32 bits suffice.
    assign w_rem_sh = {r_rem, r_numlo[7]};
    assign w_ge     = (w_rem_sh >= {1'b0, w_den});
    assign w_sub    = w_rem_sh[31:0] - w_den;
    assign w_rem_nx = w_ge ? w_sub : w_rem_sh[31:0];
    assign w_q_fin  = {r_q, w_ge};
    assign w_byte   = r_zero ? 8'h00 : (r_sat ? 8'hFF : w_q_fin);

    assign w_last_div   = (r_div_cnt == 4'd8);
    assign w_last_entry = (r_j == 2'd3);
    assign w_pack_full  = w_last_entry && (r_k[1:0] == 2'b11);
    assign w_last_k     = (r_k == CW'(CDF_DEPTH - 1));
    assign w_last_w     = (r_w == CW'(CDF_DEPTH - 1));
    assign w_w_inc      = r_w + 1'b1;
    assign w_k_inc      = r_k + 1'b1;

    // State register
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // Next-state decode
    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE:    if (enable) w_next = S_MIN_RD;
            S_MIN_RD:  w_next = S_MIN_CHK;
            S_MIN_CHK: w_next = (w_min_found || w_last_w) ? S_MAP_RD : S_MIN_RD;
            S_MAP_RD:  w_next = S_MAP_LD;
            S_MAP_LD:  w_next = S_DIV;
            S_DIV: begin
                if (w_last_div && w_last_entry) begin
                    w_next = w_pack_full ? S_WR : S_MAP_RD;
                end
            end
            S_WR:      w_next = w_last_k ? S_DONE : S_MAP_RD;
            S_DONE:    w_next = S_IDLE;
            default:   w_next = S_IDLE;
        endcase
    end

    // Datapath: scan counters, CDF word latch, divider and pack register
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_total   <= 32'd0;
            r_cdf_min <= 32'd0;
            r_rem     <= 32'd0;
            r_w       <= '0;
            r_k       <= '0;
            r_m       <= '0;
            r_j       <= 2'd0;
            r_div_cnt <= 4'd0;
            r_word    <= 128'd0;
            r_pack    <= 128'd0;
            r_numlo   <= 8'd0;
            r_q       <= 7'd0;
            r_sat     <= 1'b0;
            r_zero    <= 1'b0;
            r_rd_addr <= 16'd0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (enable) begin
                        r_total   <= total_pix;
                        r_cdf_min <= 32'd0;
                        r_w       <= '0;
                        r_k       <= '0;
                        r_m       <= '0;
                        r_j       <= 2'd0;
                        r_div_cnt <= 4'd0;
                        r_pack    <= 128'd0;
                        r_rd_addr <= 16'd0;
                    end
                end
                S_MIN_CHK: begin
                    if (w_min_found) begin
                        r_cdf_min <= w_min_val;
                        r_rd_addr <= 16'd0;
                    end else if (w_last_w) begin
                        r_cdf_min <= 32'd0;
                        r_rd_addr <= 16'd0;
                    end else begin
                        r_w       <= w_w_inc;
                        r_rd_addr <= {{(16-CW){1'b0}}, w_w_inc};
                    end
                end
                S_MAP_LD: begin
                    r_word    <= cdf_mem_rd_data;
                    r_j       <= 2'd0;
                    r_div_cnt <= 4'd0;
                end
                S_DIV: begin
                    if (r_div_cnt == 4'd0) begin
                        r_zero    <= w_below;
                        r_sat     <= w_ovf;
                        r_rem     <= w_num_hi[31:0];
                        r_numlo   <= w_num[7:0];
                        r_q       <= 7'd0;
                        r_div_cnt <= 4'd1;
                    end else begin
                        r_rem   <= w_rem_nx;
                        r_numlo <= {r_numlo[6:0], 1'b0};
                        r_q     <= {r_q[5:0], w_ge};
                        if (w_last_div) begin
                            r_pack    <= {w_byte, r_pack[127:8]};
                            r_div_cnt <= 4'd0;
                            if (w_last_entry) begin
                                r_j <= 2'd0;
                                if (!w_pack_full) begin
                                    r_k       <= w_k_inc;
                                    r_rd_addr <= {{(16-CW){1'b0}}, w_k_inc};
                                end
                            end else begin
                                r_j <= r_j + 2'd1;
                            end
                        end else begin
                            r_div_cnt <= r_div_cnt + 4'd1;
                        end
                    end
                end
                S_WR: begin
                    r_m <= r_m + 1'b1;
                    if (!w_last_k) begin
                        r_k       <= w_k_inc;
                        r_rd_addr <= {{(16-CW){1'b0}}, w_k_inc};
                    end
                end
                default: begin
                end
            endcase
        end
    end

    assign cdf_mem_rd_addr    = r_rd_addr;
    assign sc_mem_wt_en       = (r_state == S_WR);
    assign sc_mem_wt_addr     = sc_mem_wt_en ? {{(16-MW){1'b0}}, r_m} : 16'd0;
    assign sc_mem_wt_data     = sc_mem_wt_en ? r_pack : 128'd0;
    assign div_sc_mem_wt_done = (r_state == S_DONE);
    assign busy               = (r_state != S_IDLE);

endmodule

// File: tb/tb_hist_sc_tbl_gen.sv
// tb/tb_hist_sc_tbl_gen.sv - directed self-checking bench for hist_sc_tbl_gen
module tb_hist_sc_tbl_gen;

    logic         clk = 1'b0;
    logic         rst_n;
    logic         enable;
    logic [31:0]  total_pix;
    logic [15:0]  cdf_mem_rd_addr;
    logic [127:0] cdf_mem_rd_data = 128'd0;
    logic [15:0]  sc_mem_wt_addr;
    logic [127:0] sc_mem_wt_data;
    logic         sc_mem_wt_en;
    logic         div_sc_mem_wt_done;
    logic         busy;

    logic [31:0]  cdf [0:255];
    logic [127:0] log_data [0:127];
    logic [15:0]  log_addr [0:127];
    int           wr_cnt = 0;
    int           done_cnt = 0;
    int           checks = 0;
    int           failures = 0;

    hist_sc_tbl_gen dut (
        .clk                (clk),
        .reset              (rst_n),
        .enable             (enable),
        .total_pix          (total_pix),
        .cdf_mem_rd_addr    (cdf_mem_rd_addr),
        .cdf_mem_rd_data    (cdf_mem_rd_data),
        .sc_mem_wt_addr     (sc_mem_wt_addr),
        .sc_mem_wt_data     (sc_mem_wt_data),
        .sc_mem_wt_en       (sc_mem_wt_en),
        .div_sc_mem_wt_done (div_sc_mem_wt_done),
        .busy               (busy)
    );

    always #5 clk = ~clk;

    // CDF memory: one-cycle read latency
    always @(posedge clk) begin
        for (int j = 0; j < 4; j++)
            cdf_mem_rd_data[32*j +: 32] <= cdf[{cdf_mem_rd_addr[5:0], 2'(j)}];
    end

    // Scale-memory side: log every write and done pulse
    always @(negedge clk) begin
        if (sc_mem_wt_en) begin
            log_addr[wr_cnt[6:0]] <= sc_mem_wt_addr;
            log_data[wr_cnt[6:0]] <= sc_mem_wt_data;
            wr_cnt <= wr_cnt + 1;
        end
        if (div_sc_mem_wt_done) done_cnt <= done_cnt + 1;
    end

    task automatic load_linear();
        for (int i = 0; i < 256; i++) cdf[i] = 32'((i + 1) * 256);
    endtask

    task automatic load_den0();
        for (int i = 0; i < 256; i++) cdf[i] = (i < 10) ? 32'd0 : 32'd1000;
    endtask

    task automatic load_round();
        for (int i = 0; i < 256; i++) cdf[i] = (i == 0) ? 32'd1 : 32'd2;
    endtask

    task automatic run_table(input logic [31:0] tot, input bit hammer, output int cyc, output bit timed_out);
        @(negedge clk); #1;
        total_pix = tot;
        enable    = 1'b1;
        cyc       = 1;
        timed_out = 1'b1;
        for (int i = 0; i < 5000; i++) begin
            @(negedge clk); #1;
            cyc++;
            if (div_sc_mem_wt_done) begin
                enable    = 1'b0;
                timed_out = 1'b0;
                break;
            end
            enable = hammer ? ~enable : 1'b0;
        end
        enable = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0; enable = 1'b0; total_pix = 32'd0;
        repeat (2) @(negedge clk);
        #1;
        checks++;
        if ({cdf_mem_rd_addr, sc_mem_wt_addr, sc_mem_wt_en, div_sc_mem_wt_done, busy} !== 35'd0 || sc_mem_wt_data !== 128'd0) begin
            failures++;
            $display("FAIL reset_outputs: rd_addr=%0h wt_addr=%0h wt_en=%0b done=%0b busy=%0b expected all 0",
                     cdf_mem_rd_addr, sc_mem_wt_addr, sc_mem_wt_en, div_sc_mem_wt_done, busy);
        end
        rst_n = 1'b1;
        repeat (3) @(negedge clk);
        #1;
        checks++;
        if (busy !== 1'b0 || sc_mem_wt_en !== 1'b0) begin
            failures++;
            $display("FAIL idle_after_reset: busy=%0b wt_en=%0b expected 0 0", busy, sc_mem_wt_en);
        end
    endtask

    task automatic test_linear(input bit hammer, input string tag);
        int cyc; bit to; int wb; int db;
        logic [127:0] exp;
        load_linear();
        wb = wr_cnt; db = done_cnt;
        run_table(32'd65536, hammer, cyc, to);
        checks++;
        if (to) begin failures++; $display("FAIL %s_timeout: no done within budget", tag); end
        checks++;
        if (cyc != 2452) begin failures++; $display("FAIL %s_cycles: got %0d expected 2452", tag, cyc); end
        @(negedge clk); #1;
        checks++;
        if (div_sc_mem_wt_done !== 1'b0 || busy !== 1'b0) begin
            failures++; $display("FAIL %s_after_done: done=%0b busy=%0b expected 0 0", tag, div_sc_mem_wt_done, busy);
        end
        repeat (40) @(negedge clk);
        #1;
        checks++;
        if (wr_cnt - wb != 16) begin failures++; $display("FAIL %s_write_count: got %0d expected 16", tag, wr_cnt - wb); end
        checks++;
        if (done_cnt - db != 1) begin failures++; $display("FAIL %s_done_count: got %0d expected 1", tag, done_cnt - db); end
        for (int m = 0; m < 16; m++) begin
            for (int n = 0; n < 16; n++) exp[8*n +: 8] = 8'(16 * m + n);
            checks++;
            if (log_addr[(wb + m) % 128] !== 16'(m) || log_data[(wb + m) % 128] !== exp) begin
                failures++;
                $display("FAIL %s_word%0d: addr=%0d data=%h expected addr=%0d data=%h",
                         tag, m, log_addr[(wb + m) % 128], log_data[(wb + m) % 128], m, exp);
            end
        end
    endtask

    task automatic test_den_zero();
        int cyc; bit to; int wb;
        logic [127:0] exp;
        load_den0();
        wb = wr_cnt;
        run_table(32'd1000, 1'b0, cyc, to);
        checks++;
        if (to || cyc != 2456) begin failures++; $display("FAIL den0_cycles: got %0d timeout=%0b expected 2456", cyc, to); end
        @(negedge clk); #1;
        checks++;
        if (wr_cnt - wb != 16) begin failures++; $display("FAIL den0_write_count: got %0d expected 16", wr_cnt - wb); end
        for (int m = 0; m < 16; m++) begin
            for (int n = 0; n < 16; n++) exp[8*n +: 8] = (16 * m + n < 10) ? 8'h00 : 8'hFF;
            checks++;
            if (log_data[(wb + m) % 128] !== exp) begin
                failures++;
                $display("FAIL den0_word%0d: got %h expected %h", m, log_data[(wb + m) % 128], exp);
            end
        end
    endtask

    task automatic test_round();
        int cyc; bit to; int wb;
        logic [127:0] exp;
        logic [7:0] one_val;
`ifdef HIST_SC_ROUND_EN
        one_val = 8'h01;
`else
        one_val = 8'h00;
`endif
        load_round();
        wb = wr_cnt;
        run_table(32'd511, 1'b0, cyc, to);
        checks++;
        if (to || cyc != 2452) begin failures++; $display("FAIL round_cycles: got %0d timeout=%0b expected 2452", cyc, to); end
        @(negedge clk); #1;
        for (int m = 0; m < 16; m += 5) begin
            for (int n = 0; n < 16; n++) exp[8*n +: 8] = (16 * m + n == 0) ? 8'h00 : one_val;
            checks++;
            if (log_data[(wb + m) % 128] !== exp) begin
                failures++;
                $display("FAIL round_word%0d: got %h expected %h", m, log_data[(wb + m) % 128], exp);
            end
        end
    endtask

    task automatic test_reset_mid();
        int wb; int db; bit seen;
        load_linear();
        wb = wr_cnt; db = done_cnt; seen = 1'b0;
        @(negedge clk); #1;
        total_pix = 32'd65536;
        enable = 1'b1;
        @(negedge clk); #1;
        enable = 1'b0;
        for (int i = 0; i < 3000; i++) begin
            @(negedge clk); #1;
            if (wr_cnt - wb >= 3) begin seen = 1'b1; break; end
        end
        checks++;
        if (!seen) begin failures++; $display("FAIL midreset_third_write: writes=%0d expected 3", wr_cnt - wb); end
        rst_n = 1'b0;
        #1;
        checks++;
        if ({cdf_mem_rd_addr, sc_mem_wt_addr, sc_mem_wt_en, div_sc_mem_wt_done, busy} !== 35'd0 || sc_mem_wt_data !== 128'd0) begin
            failures++;
            $display("FAIL midreset_outputs: rd_addr=%0h wt_addr=%0h wt_en=%0b done=%0b busy=%0b expected all 0",
                     cdf_mem_rd_addr, sc_mem_wt_addr, sc_mem_wt_en, div_sc_mem_wt_done, busy);
        end
        repeat (3) @(negedge clk);
        #1;
        rst_n = 1'b1;
        repeat (200) @(negedge clk);
        #1;
        checks++;
        if (wr_cnt - wb != 3 || done_cnt != db || busy !== 1'b0) begin
            failures++;
            $display("FAIL midreset_quiet: writes=%0d done=%0d busy=%0b expected 3 0 0", wr_cnt - wb, done_cnt - db, busy);
        end
        test_linear(1'b0, "rerun");
    endtask

    initial begin
        test_reset();
        test_linear(1'b0, "linear");
        test_den_zero();
        test_round();
        test_reset_mid();
        test_linear(1'b1, "b2b");
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
